flit_buffer: RTL and testbench
==============================

# flit_buffer

Single-clock flit FIFO between a `packet_source` output channel and one router `rx` port, giving each router input DEPTH flits of elastic buffering. It accepts flits from upstream on a req/ack channel and presents them in order to the router on an identical req/ack channel. It also reports occupancy and a wrapping count of forwarded flits for bench-side bookkeeping.

## Interface

- `SIZE`, 8, flit width in bits (matches router `SIZE`)
- `DEPTH`, 4, number of flit entries; must be a power of two, ≥ 2
- `ADDR_BITS`, 2, log2(DEPTH)
- `CNT_BITS`, 16, width of forwarded-flit counter

- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `rx_ch_req`  in  1  upstream flit valid
- `rx_ch_ack`  out  1  buffer can accept a flit this cycle
- `rx_ch_data`  in  SIZE  upstream flit
- `tx_ch_req`  out  1  buffer holds a flit for the router
- `tx_ch_ack`  in  1  router accepts head flit this cycle
- `tx_ch_data`  out  SIZE  head flit
- `count`  out  ADDR_BITS+1  current occupancy, 0..DEPTH
- `fwd_flits`  out  CNT_BITS  total flits popped since reset, wraps modulo 2^CNT_BITS

## Operation

- Channel rule, both sides: a flit transfers on a rising edge where req and ack are both 1. No other edge moves data.
- Storage: DEPTH×SIZE register array, write pointer `wr_ptr`, read pointer `rd_ptr`, both ADDR_BITS wide, both wrap DEPTH-1 → 0 naturally. Occupancy register `count` is ADDR_BITS+1 bits.
- `rx_ch_ack = (count != DEPTH)`. It is combinational from state only and does not depend on `tx_ch_ack`. No write-through when full.
- `tx_ch_req = (count != 0)`, `tx_ch_data = mem[rd_ptr]`. There is no bypass: an empty buffer never presents the incoming flit combinationally.
- Push on an edge where `rx_ch_req & rx_ch_ack`: `mem[wr_ptr] <= rx_ch_data`, `wr_ptr <= wr_ptr+1`.
- Pop on an edge where `tx_ch_req & tx_ch_ack`: `rd_ptr <= rd_ptr+1`, `fwd_flits <= fwd_flits+1`.
- Count update: push only gives +1. Pop only gives −1. Push and pop together leave `count` unchanged, and both pointers advance. This is legal at any occupancy 1..DEPTH-1.
- Ignored inputs:
  - `rx_ch_req` while full is ignored. Upstream must hold req and data until ack.
  - `tx_ch_ack` while empty is ignored, with no pointer or counter change.
- Head stability: while `tx_ch_req=1` and no pop occurs, `tx_ch_data` is unchanged, even when a push occurs the same cycle.
- Flit order is strictly preserved. No flit is duplicated or lost.
- Reset (`reset=0`, asynchronous, effective immediately, including mid-transfer):
  - `wr_ptr`, `rd_ptr`, `count` and `fwd_flits` go to 0, so `rx_ch_ack=1`, `tx_ch_req=0` and `fwd_flits=0`.
  - Memory contents are not reset.
  - Any flit held at assertion is discarded.
- Reset release is synchronised by the surrounding design. The block only requires that `reset` not deassert coincident with a transfer edge.

## Timing

- Latency: a flit pushed at edge k appears on `tx_ch_data` with `tx_ch_req=1` after edge k. It can be popped at edge k+1 at the earliest.
- Throughput: one flit per cycle sustained when both sides are continuously ready. In steady state `count` stays at 1.
- Fill: with `tx_ch_ack=0` and `rx_ch_req=1` from reset, `rx_ch_ack` drops after the DEPTH-th push edge.
- Drain: `rx_ch_ack` returns to 1 after the first pop edge from full. Upstream's next push can land on that following edge.
- `count`, `rx_ch_ack` and `tx_ch_req` all change only after rising edges or on asynchronous reset assertion.

## Test plan

- Reset values: hold `reset=0`, drive random inputs → `rx_ch_ack=1`, `tx_ch_req=0`, `count=0`, `fwd_flits=0` throughout.
- Single flit: push 0xA5 at edge 1 with `tx_ch_ack=0` → after edge 1, `tx_ch_req=1`, `tx_ch_data=0xA5`, `count=1`. Ack at edge 3 → `count=0`, `fwd_flits=1`.
- Fill and backpressure (DEPTH=4): push 0x01..0x05 with `tx_ch_ack=0` → `rx_ch_ack=0` after 4th push, 0x05 is held off, `count=4`. Release ack → pops in order 0x01,0x02,0x03,0x04,0x05, and 0x05 enters on the edge after the first pop.
- Streaming and wrap: both sides ready for 10 cycles with flits 0x10..0x19 → outputs 0x10..0x19 in order, one per cycle from the cycle after the first push. `count` stays ≤1, pointers wrap twice, `fwd_flits=10`.
- Simultaneous push/pop at `count=2` → `count` stays 2, head advances, order preserved. Ack while empty → no change to `fwd_flits`.
- Mid-operation reset: assert `reset=0` asynchronously with `count=3` between edges → immediately `count=0`, `tx_ch_req=0`, `rx_ch_ack=1`. After release, a new flit 0x3C is the first output.

Source files
------------

// File: rtl/flit_buffer_if.sv
// Flit channel: req/ack handshake carrying one SIZE-bit flit.
//   req  - sender has a valid flit
//   ack  - receiver can take the flit this cycle
//   data - flit payload
// A flit moves on a rising edge where req and ack are both high.
interface flit_ch_if #(
  parameter int unsigned SIZE = 8
);
  logic            req;
  logic            ack;
  logic [SIZE-1:0] data;

  modport master (output req, output data, input ack);
  modport slave  (input req, input data, output ack);
endinterface

// File: rtl/flit_buffer.sv
// flit_buffer: single-clock DEPTH-entry flit FIFO between an upstream source
// and a router input port, with occupancy and forwarded-flit reporting.
// Ports:
//   clk       - system clock, all state changes on the rising edge
//   reset     - asynchronous active-low reset
//   rx_ch     - upstream channel (slave side: req/data in, ack out)
//   tx_ch     - router channel (master side: req/data out, ack in)
//   count     - current occupancy, 0..DEPTH
//   fwd_flits - flits popped since reset, wraps modulo 2^CNT_BITS
module flit_buffer #(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_BITS = 2,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                clk,
  input  logic                reset,
  flit_ch_if.slave            rx_ch,
  flit_ch_if.master           tx_ch,
  output logic [ADDR_BITS:0]  count,
  output logic [CNT_BITS-1:0] fwd_flits
);

  localparam int unsigned CW = ADDR_BITS + 1;

  logic [SIZE-1:0]      mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CNT_BITS-1:0]  fwd_q, fwd_d;
  logic                 ack_q, ack_d;
  logic                 req_q, req_d;
  logic                 push_c;
  logic                 pop_c;

  // Handshake flags are kept as flops that mirror (count != DEPTH) and
  // (count != 0), so they depend on state only and never on the far side.
  assign push_c = rx_ch.req & ack_q;
  assign pop_c  = req_q & tx_ch.ack;

  // Next-state logic for pointers, occupancy, counter and handshake flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    fwd_d    = fwd_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
      fwd_d    = fwd_q + CNT_BITS'(1);
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ack_d = (count_d != CW'(DEPTH));
    req_d = (count_d != CW'(0));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fwd_q    <= '0;
      ack_q    <= 1'b1;
      req_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fwd_q    <= fwd_d;
      ack_q    <= ack_d;
      req_q    <= req_d;
    end
  end

  // Flit storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= rx_ch.data;
    end
  end

  assign rx_ch.ack  = ack_q;
  assign tx_ch.req  = req_q;
  assign tx_ch.data = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign fwd_flits  = fwd_q;

endmodule

// File: tb/tb_flit_buffer.sv
// Directed bench for flit_buffer (SIZE=8, DEPTH=4).
module tb_flit_buffer;

  logic        clk;
  logic        reset;
  logic [2:0]  count;
  logic [15:0] fwd_flits;
  int          n_checks;
  int          n_fails;

  flit_ch_if #(.SIZE(8)) rx_if ();
  flit_ch_if #(.SIZE(8)) tx_if ();

  flit_buffer #(
    .SIZE(8), .DEPTH(4), .ADDR_BITS(2), .CNT_BITS(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_ch     (rx_if),
    .tx_ch     (tx_if),
    .count     (count),
    .fwd_flits (fwd_flits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_q [5];
    n_checks = 0;
    n_fails  = 0;

    // Reset held with random inputs.
    reset = 1'b0;
    rx_if.req = 1'b0; rx_if.data = '0; tx_if.ack = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      rx_if.req  = 1'($urandom_range(0, 1));
      rx_if.data = 8'($urandom);
      tx_if.ack  = 1'($urandom_range(0, 1));
      tick();
      check_eq("rst_ack", 32'(rx_if.ack), 32'd1);
      check_eq("rst_req", 32'(tx_if.req), 32'd0);
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_fwd", 32'(fwd_flits), 32'd0);
    end
    rx_if.req = 1'b0; tx_if.ack = 1'b0;
    reset = 1'b1;

    // Single flit.
    rx_if.req = 1'b1; rx_if.data = 8'hA5;
    tick();
    rx_if.req = 1'b0;
    check_eq("single_req", 32'(tx_if.req), 32'd1);
    check_eq("single_data", 32'(tx_if.data), 32'hA5);
    check_eq("single_count", 32'(count), 32'd1);
    tick();
    check_eq("single_hold", 32'(tx_if.data), 32'hA5);
    tx_if.ack = 1'b1;
    tick();
    tx_if.ack = 1'b0;
    check_eq("single_pop_count", 32'(count), 32'd0);
    check_eq("single_fwd", 32'(fwd_flits), 32'd1);
    check_eq("single_req0", 32'(tx_if.req), 32'd0);

    // Fill and backpressure.
    rx_if.req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      rx_if.data = 8'(i);
      tick();
      check_eq("fill_count", 32'(count), 32'(i));
    end
    check_eq("full_ack", 32'(rx_if.ack), 32'd0);
    rx_if.data = 8'h05;
    tick();
    check_eq("full_count_held", 32'(count), 32'd4);
    check_eq("full_head", 32'(tx_if.data), 32'h01);
    exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h03;
    exp_q[3] = 8'h04; exp_q[4] = 8'h05;
    tx_if.ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_eq("drain_head", 32'(tx_if.data), 32'(exp_q[k]));
      check_eq("drain_req", 32'(tx_if.req), 32'd1);
      tick();
      if (k == 0) begin
        check_eq("drain_ack_back", 32'(rx_if.ack), 32'd1);
        check_eq("drain_count0", 32'(count), 32'd3);
      end
      if (k == 1) begin
        rx_if.req = 1'b0;
        check_eq("drain_pushpop", 32'(count), 32'd3);
      end
    end
    check_eq("drain_empty", 32'(count), 32'd0);
    check_eq("drain_fwd", 32'(fwd_flits), 32'd6);

    // Streaming with pointer wrap.
    rx_if.req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rx_if.data = 8'(8'h10 + i);
      tick();
      check_eq("stream_head", 32'(tx_if.data), 32'(8'h10 + i));
      check_eq("stream_count", 32'(count), 32'd1);
    end
    rx_if.req = 1'b0;
    tick();
    tx_if.ack = 1'b0;
    check_eq("stream_empty", 32'(count), 32'd0);
    check_eq("stream_fwd", 32'(fwd_flits), 32'd16);

    // Simultaneous push/pop at count=2, then ack while empty.
    rx_if.req = 1'b1; rx_if.data = 8'h21;
    tick();
    rx_if.data = 8'h22;
    tick();
    check_eq("pp_count2", 32'(count), 32'd2);
    rx_if.data = 8'h23; tx_if.ack = 1'b1;
    tick();
    rx_if.req = 1'b0;
    check_eq("pp_count_same", 32'(count), 32'd2);
    check_eq("pp_head", 32'(tx_if.data), 32'h22);
    tick();
    check_eq("pp_head2", 32'(tx_if.data), 32'h23);
    tick();
    check_eq("pp_empty", 32'(count), 32'd0);
    check_eq("pp_fwd", 32'(fwd_flits), 32'd19);
    tick();
    tick();
    check_eq("empty_ack_fwd", 32'(fwd_flits), 32'd19);
    check_eq("empty_ack_count", 32'(count), 32'd0);
    tx_if.ack = 1'b0;

    // Mid-operation asynchronous reset.
    rx_if.req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_if.data = 8'(8'h31 + i);
      tick();
    end
    rx_if.req = 1'b0;
    check_eq("mr_count3", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mr_count", 32'(count), 32'd0);
    check_eq("mr_req", 32'(tx_if.req), 32'd0);
    check_eq("mr_ack", 32'(rx_if.ack), 32'd1);
    check_eq("mr_fwd", 32'(fwd_flits), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rx_if.req = 1'b1; rx_if.data = 8'h3C;
    tick();
    rx_if.req = 1'b0;
    check_eq("mr_new_head", 32'(tx_if.data), 32'h3C);
    check_eq("mr_new_count", 32'(count), 32'd1);
    tx_if.ack = 1'b1;
    tick();
    tx_if.ack = 1'b0;
    check_eq("mr_pop_count", 32'(count), 32'd0);
    check_eq("mr_pop_fwd", 32'(fwd_flits), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
